cycle_reg_sequencer: RTL and testbench

Controller that fills a bank of `WIDTH` double-buffered cycle registers from a host-supplied pattern and commits all of them at once. Each register has a buffer stage and an output stage. The controller loads the buffer stages one register per clock over a shared serial data line. It then waits for the tester's cycle-boundary strobe and pulses a single common TRANSFER, so every register output changes on the same edge. It sits between the host/pattern-memory interface and the per-pin cycle register bank of the ASIC tester.

---
 rtl/cycle_reg_sequencer_if.sv | 26 ++
 rtl/cycle_reg_sequencer.sv | 84 ++++++++
 tb/tb_cycle_reg_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cycle_reg_sequencer_if.sv
// Host/tester-side signal bundle for the cycle register sequencer.
// master = host and tester (pattern source, SYNC/ABORT), slave = sequencer.
interface cycle_reg_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             PAT_VALID;
    logic             PAT_READY;
    logic [WIDTH-1:0] PATTERN;
    logic             SYNC;
    logic             ABORT;
    logic [WIDTH-1:0] LOAD;
    logic             D_OUT;
    logic             TRANSFER;
    logic             BUSY;
    logic             DONE;

    modport master (
        output PAT_VALID, PATTERN, SYNC, ABORT,
        input  PAT_READY, LOAD, D_OUT, TRANSFER, BUSY, DONE
    );

    modport slave (
        input  PAT_VALID, PATTERN, SYNC, ABORT,
        output PAT_READY, LOAD, D_OUT, TRANSFER, BUSY, DONE
    );
endinterface

// File: rtl/cycle_reg_sequencer.sv
// Loads a bank of double-buffered cycle registers one per clock over a serial line,
// then issues a single common TRANSFER on the next tester cycle-boundary strobe.
module cycle_reg_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   CLK,
    input logic                   RST,
    cycle_reg_sequencer_if.slave  bus
);
    localparam int unsigned IW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StLoading, StArmed, StCommit} state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic [WIDTH-1:0] load_q;
    logic             d_out_q;
    logic             transfer_q;
    logic             done_q;

    // idx names the register whose LOAD strobe is on the bus this cycle.
    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= StIdle;
            shadow     <= '0;
            idx        <= '0;
            load_q     <= '0;
            d_out_q    <= 1'b0;
            transfer_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            load_q     <= '0;
            d_out_q    <= 1'b0;
            transfer_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.PAT_VALID) begin
                        shadow  <= bus.PATTERN;
                        idx     <= '0;
                        load_q  <= WIDTH'(1);
                        d_out_q <= bus.PATTERN[0];
                        state   <= StLoading;
                    end
                end
                StLoading: begin
                    if (bus.ABORT) begin
                        state <= StIdle;
                    end else if (idx == IW'(WIDTH - 1)) begin
                        state <= StArmed;
                    end else begin
                        idx     <= idx_nxt;
                        load_q  <= WIDTH'(1) << idx_nxt;
                        d_out_q <= shadow[idx_nxt];
                    end
                end
                StArmed: begin
                    // ABORT wins over a coincident SYNC.
                    if (bus.ABORT) begin
                        state <= StIdle;
                    end else if (bus.SYNC) begin
                        transfer_q <= 1'b1;
                        done_q     <= 1'b1;
                        state      <= StCommit;
                    end
                end
                StCommit: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.PAT_READY = (state == StIdle);
    assign bus.BUSY      = (state != StIdle);
    assign bus.LOAD      = load_q;
    assign bus.D_OUT     = d_out_q;
    assign bus.TRANSFER  = transfer_q;
    assign bus.DONE      = done_q;
endmodule

// File: tb/tb_cycle_reg_sequencer.sv
// Bench for cycle_reg_sequencer: directed scenarios plus random traffic, checked
// against a timestamp-based reference model and a modelled register bank.
module tb_cycle_reg_sequencer;
    localparam int unsigned WIDTH = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    cycle_reg_sequencer_if #(.WIDTH(WIDTH)) bus ();
    cycle_reg_sequencer #(.WIDTH(WIDTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: acceptance edge and commit edge timestamps (-1 = none).
    int               edge_n = -1;
    int               acc    = -1;
    int               com    = -1;
    logic [WIDTH-1:0] mpat   = '0;
    logic [WIDTH-1:0] exp_bank = '0;

    // Modelled per-pin register bank driven by the DUT's outputs.
    logic [WIDTH-1:0] bank_buf = '0;
    logic [WIDTH-1:0] bank_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge(input logic v, input logic [WIDTH-1:0] p, input logic s,
                              input logic ab);
        edge_n++;
        if (acc < 0) begin
            if (v) begin
                acc  = edge_n;
                mpat = p;
            end
        end else if (com >= 0) begin
            acc = -1;
            com = -1;
            exp_bank = mpat;
        end else if (ab) begin
            acc = -1;
        end else if ((edge_n - 1 - acc) >= int'(WIDTH) && s) begin
            com = edge_n;
        end
    endtask

    task automatic check_cycle();
        logic             busy;
        logic [WIDTH-1:0] el;
        logic             ed;
        int               j;
        busy = (acc >= 0);
        el   = '0;
        ed   = 1'b0;
        j    = edge_n - acc;
        if (busy && com < 0 && j < int'(WIDTH)) begin
            el[j] = 1'b1;
            ed    = mpat[j];
        end
        chk("load", bus.LOAD, el);
        chk("d_out", bus.D_OUT, ed);
        chk("transfer", bus.TRANSFER, busy && com == edge_n);
        chk("done", bus.DONE, busy && com == edge_n);
        chk("busy", bus.BUSY, busy);
        chk("pat_ready", bus.PAT_READY, !busy);
        chk("bank_out", bank_out, exp_bank);
        chk("load_onehot0", $onehot0(bus.LOAD), 1);
        chk("load_xfer_overlap", (|bus.LOAD) && bus.TRANSFER, 0);
        chk("dout_without_load", (bus.LOAD == '0) && bus.D_OUT, 0);
        // Bank latches at the upcoming edge; LOAD has priority over TRANSFER.
        if (bus.LOAD != '0) begin
            for (int i = 0; i < int'(WIDTH); i++)
                if (bus.LOAD[i]) bank_buf[i] = bus.D_OUT;
        end else if (bus.TRANSFER) begin
            bank_out = bank_buf;
        end
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] p, input logic s,
                        input logic ab);
        bus.PAT_VALID = v;
        bus.PATTERN   = p;
        bus.SYNC      = s;
        bus.ABORT     = ab;
        @(posedge CLK);
        model_edge(v, p, s, ab);
        #1;
        check_cycle();
    endtask

    task automatic idle_steps(input int n, input logic s);
        for (int k = 0; k < n; k++) step(1'b0, WIDTH'($urandom), s, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        chk("rst_load", bus.LOAD, 0);
        chk("rst_d_out", bus.D_OUT, 0);
        chk("rst_transfer", bus.TRANSFER, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_pat_ready", bus.PAT_READY, 1);
        acc = -1;
        com = -1;
        bus.PAT_VALID = 1'b1;
        bus.PATTERN   = WIDTH'($urandom);
        @(posedge CLK);
        #1;
        check_cycle();
        #2;
        RST = 1'b0;
        bus.PAT_VALID = 1'b0;
    endtask

    initial begin
        bus.PAT_VALID = 1'b0;
        bus.PATTERN   = '0;
        bus.SYNC      = 1'b0;
        bus.ABORT     = 1'b0;
        async_reset();

        // 0xA5 with SYNC held high: minimum-latency commit.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        idle_steps(12, 1'b1);

        // 0x3C with SYNC delayed 20 cycles after ARMED.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        idle_steps(8 + 20, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle_steps(3, 1'b0);

        // SYNC pulses only during LOADING are ignored.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 8'h00, k[0], 1'b0);
        idle_steps(6, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle_steps(3, 1'b0);

        // ABORT at idx 4, then ABORT together with SYNC in ARMED.
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        idle_steps(4, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle_steps(2, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        idle_steps(8, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle_steps(3, 1'b1);

        // Reset pulsed at idx 3, then 0xFF completes normally.
        step(1'b1, 8'h81, 1'b0, 1'b0);
        idle_steps(3, 1'b0);
        async_reset();
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        idle_steps(12, 1'b1);

        // Host holds PAT_VALID with a new pattern while busy.
        step(1'b1, 8'h11, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b1, 8'h22, 1'b1, 1'b0);
        idle_steps(12, 1'b1);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 3) == 0, WIDTH'($urandom),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
